pe_ws_dbuf: RTL and testbench
=============================

Name: pe_ws_dbuf

Overview:
- Parametrised weight-stationary processing element for the systolic array. Next generation of the current PE.
- Adds a double-buffered weight: a shadow register shifts down the column while the active weight keeps computing. A weight swap commits the shadow to active without stalling the stream.
- Carries valid qualifiers on activations and partial sums. Uses an inline pipelined MAC with configurable latency instead of a vendor DSP macro.
- Tiles into the same row/column fabric: acts flow left to right, weights and psums flow top to bottom.

Parameters:
- DATA_W, 8: activation/weight width.
- PSUM_W, 32: partial-sum width. Must be at least 2*DATA_W+1.
- ACT_DELAY, 1: register stages on the act/valid forward path (≥1).
- MAC_LAT, 2: cycles from act sample to out_down_psum (≥1).
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- weight_load  in  1  shift the column weight chain by one.
- weight_swap  in  1  commit shadow weight to active weight.
- in_up_weight  in  DATA_W  weight from PE above (or column feeder).
- out_down_weight  out  DATA_W  current shadow weight, to PE below.
- in_left_act  in  DATA_W  activation from left.
- in_left_valid  in  1  in_left_act qualifier.
- out_right_act  out  DATA_W  activation forwarded right.
- out_right_valid  out  1  forwarded qualifier.
- in_up_psum  in  PSUM_W  partial sum from above.
- out_down_psum  out  PSUM_W  partial sum to below.
- out_down_psum_valid  out  1  out_down_psum qualifier.

Behaviour:
- Reset (rst=0): asynchronously clears shadow, active weight, every pipeline and delay stage, and every output, including all valids. In-flight MACs are discarded. Activity resumes on the first edge after rst rises.
- Weight chain: on weight_load=1, shadow <= in_up_weight. out_down_weight is driven directly from the shadow register.
  - N load pulses fill an N-row column; the first word issued ends in the bottom row.
  - With weight_load=0, shadow holds.
- Swap: on weight_swap=1, active <= shadow (pre-edge value).
  - Load and swap in the same cycle: active takes the old shadow; shadow takes in_up_weight.
  - Swap never stalls or zeroes the act/psum streams.
- MAC issue (stage 0): samples in_left_act, in_left_valid, in_up_psum and the active weight at the same edge.
  - Product is 2*DATA_W wide, signed or unsigned per SIGNED, then sign/zero-extended to PSUM_W.
  - Sum = in_up_psum + ext(product) when valid=1. Sum = in_up_psum unchanged when valid=0 (product gated to 0).
  - Sum wraps modulo 2^PSUM_W.
  - out_down_psum and out_down_psum_valid appear exactly MAC_LAT cycles after issue. Fully pipelined: one op per cycle.
  - An op issued before a swap edge uses the old weight; an op issued at or after it uses the new one.
- Act forward: out_right_act and out_right_valid equal in_left_act and in_left_valid delayed ACT_DELAY cycles. Weight loading does not clear or block this path.
- Valid gating: out_down_psum_valid = in_left_valid delayed MAC_LAT cycles. Psum data still propagates when valid=0, so downstream accumulation stays aligned.

Optional Feature:
- PE_PSUM_SAT_EN defined: the final add saturates.
  - SIGNED=1: clamps to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - SIGNED=0: clamps to 2^PSUM_W-1.
  - The saturation compare sits in the last MAC stage; latency is unchanged.
- PE_PSUM_SAT_EN undefined: modulo wrap, no extra logic.

Decomposition:
- pe_pkg:
  - default DATA_W/PSUM_W constants;
  - typedefs act_t, weight_t, psum_t;
  - function ext_prod(product, signed_mode);
  - function sat_add(a, b, signed_mode), used only under PE_PSUM_SAT_EN.
- Sub-module pe_delay_line: parametrised WIDTH/DEPTH shift register with async active-low reset. Instanced for the act+valid forward path and for the MAC_LAT-1 psum/valid output stages.

Test Plan:
- Reset mid-stream: drive rst=0 with valids high -> all outputs 0 immediately, before the next edge. After release, the first valid act gives a psum MAC_LAT cycles later.
- Weight chain (2 PEs stacked): load 3 then 5, then swap -> top active=5, bottom active=3, top out_down_weight=5.
- MAC (defaults): active=5, act=-3 valid, in_up_psum=100 -> out_down_psum=85 with valid=1 exactly 2 cycles later; out_right_act=-3 with valid=1 after 1 cycle.
- Swap during stream: back-to-back act=2, 2, in_up_psum=0, swap to 7 at the second edge -> psums 10 then 14.
- Invalid act: valid=0, act=9, in_up_psum=42 -> out_down_psum=42, out_down_psum_valid=0.
- Width boundary:
  - in_up_psum=0x7FFFFFFF, act=1, weight=1 -> 0x80000000 without PE_PSUM_SAT_EN; 0x7FFFFFFF with it.
  - SIGNED=0, act=weight=0xFF -> 65025.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, default widths and arithmetic helpers for the weight-stationary PE.
// Helpers work on a 64-bit container; callers pass the live width and truncate the result.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PSUM_W_DEF = 32;
  localparam int MAX_W      = 64;

  typedef logic [DATA_W_DEF-1:0] act_t;
  typedef logic [DATA_W_DEF-1:0] weight_t;
  typedef logic [PSUM_W_DEF-1:0] psum_t;
  typedef logic [MAX_W-1:0]      wide_t;

  // Sign- or zero-extend the low prod_w bits of product to the full container.
  function automatic wide_t ext_prod(input wide_t product, input int prod_w,
                                     input logic signed_mode);
    wide_t r;
    logic  msb;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == prod_w - 1) msb = product[i] & signed_mode;
    end
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < prod_w) ? product[i] : msb;
    end
    return r;
  endfunction

  // Add two w-bit values (zero-padded in the container) and clamp on overflow.
  function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                    input logic signed_mode, input int w);
    logic [MAX_W:0] s;
    wide_t          lo_mask;
    wide_t          smax;
    wide_t          smin;
    logic           sa;
    logic           sb;
    logic           ss;
    logic           carry;
    s     = {1'b0, a} + {1'b0, b};
    sa    = 1'b0;
    sb    = 1'b0;
    ss    = 1'b0;
    carry = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      lo_mask[i] = (i < w);
      smax[i]    = (i < w - 1);
      smin[i]    = (i == w - 1);
      if (i == w - 1) begin
        sa = a[i];
        sb = b[i];
        ss = s[i];
      end
    end
    for (int i = 0; i <= MAX_W; i++) begin
      if (i == w) carry = s[i];
    end
    if (signed_mode) begin
      if ((sa == sb) && (ss != sa)) return sa ? smin : smax;
      return s[MAX_W-1:0] & lo_mask;
    end
    if (carry) return lo_mask;
    return s[MAX_W-1:0] & lo_mask;
  endfunction

endpackage

// File: rtl/pe_delay_line.sv
// WIDTH-bit shift register of DEPTH stages with asynchronous active-low clear.
// DEPTH=0 collapses to a wire.
module pe_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign stage_d[gi] = d;
        end else begin : g_tail
          assign stage_d[gi] = stage_q[gi-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with double-buffered weight and an inline pipelined MAC.
// Define PE_PSUM_SAT_EN to make the accumulate saturate instead of wrapping.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PSUM_W    = PSUM_W_DEF,
  parameter int ACT_DELAY = 1,
  parameter int MAC_LAT   = 2,
  parameter int SIGNED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              weight_load,
  input  logic              weight_swap,
  input  logic [DATA_W-1:0] in_up_weight,
  output logic [DATA_W-1:0] out_down_weight,
  input  logic [DATA_W-1:0] in_left_act,
  input  logic              in_left_valid,
  output logic [DATA_W-1:0] out_right_act,
  output logic              out_right_valid,
  input  logic [PSUM_W-1:0] in_up_psum,
  output logic [PSUM_W-1:0] out_down_psum,
  output logic              out_down_psum_valid
);

  localparam logic SIGNED_B = (SIGNED != 0);

  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [PSUM_W-1:0]   psum_q, psum_d;
  logic                psum_valid_q, psum_valid_d;
  logic [2*DATA_W-1:0] act_x, wgt_x, prod;
  logic [PSUM_W-1:0]   prod_gated;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (weight_load) shadow_d = in_up_weight;
    if (weight_swap) active_d = shadow_q;
  end

  // The op issued on the swap edge already sees the committed weight, hence active_d.
  always_comb begin
    act_x      = {{DATA_W{SIGNED_B & in_left_act[DATA_W-1]}}, in_left_act};
    wgt_x      = {{DATA_W{SIGNED_B & active_d[DATA_W-1]}}, active_d};
    prod       = act_x * wgt_x;
    prod_gated = in_left_valid ? PSUM_W'(ext_prod(MAX_W'(prod), 2 * DATA_W, SIGNED_B)) : '0;
`ifdef PE_PSUM_SAT_EN
    psum_d     = PSUM_W'(sat_add(MAX_W'(in_up_psum), MAX_W'(prod_gated), SIGNED_B, PSUM_W));
`else
    psum_d     = in_up_psum + prod_gated;
`endif
    psum_valid_d = in_left_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
    end
  end

  assign out_down_weight = shadow_q;

  pe_delay_line #(
    .WIDTH (DATA_W + 1),
    .DEPTH (ACT_DELAY)
  ) u_act_dly (
    .clk   (clk),
    .rst_n (rst),
    .d     ({in_left_valid, in_left_act}),
    .q     ({out_right_valid, out_right_act})
  );

  // Remaining MAC_LAT-1 stages only retime the finished sum.
  pe_delay_line #(
    .WIDTH (PSUM_W + 1),
    .DEPTH (MAC_LAT - 1)
  ) u_psum_dly (
    .clk   (clk),
    .rst_n (rst),
    .d     ({psum_valid_q, psum_q}),
    .q     ({out_down_psum_valid, out_down_psum})
  );

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench: two signed PEs stacked on one weight column plus an unsigned PE.
// Expected psums/acts are queued at drive time and popped when their latency elapses.
module tb_pe_ws_dbuf;

  localparam int DW        = 8;
  localparam int PW        = 32;
  localparam int ACT_DELAY = 1;
  localparam int MAC_LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          weight_load = 1'b0;
  logic          weight_swap = 1'b0;
  logic [DW-1:0] in_w = '0;
  logic [DW-1:0] act = '0;
  logic          valid = 1'b0;
  logic [PW-1:0] psum = '0;

  logic [DW-1:0] t_wout, t_ract, b_wout, b_ract, u_wout, u_ract;
  logic          t_rv, t_pv, b_rv, b_pv, u_rv, u_pv;
  logic [PW-1:0] t_psum, b_psum, u_psum;

  always #5 clk = ~clk;

  pe_ws_dbuf #(.DATA_W(DW), .PSUM_W(PW), .ACT_DELAY(ACT_DELAY), .MAC_LAT(MAC_LAT), .SIGNED(1)) u_top (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_swap(weight_swap),
    .in_up_weight(in_w), .out_down_weight(t_wout),
    .in_left_act(act), .in_left_valid(valid), .out_right_act(t_ract), .out_right_valid(t_rv),
    .in_up_psum(psum), .out_down_psum(t_psum), .out_down_psum_valid(t_pv));

  pe_ws_dbuf #(.DATA_W(DW), .PSUM_W(PW), .ACT_DELAY(ACT_DELAY), .MAC_LAT(MAC_LAT), .SIGNED(1)) u_bot (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_swap(weight_swap),
    .in_up_weight(t_wout), .out_down_weight(b_wout),
    .in_left_act(act), .in_left_valid(valid), .out_right_act(b_ract), .out_right_valid(b_rv),
    .in_up_psum(psum), .out_down_psum(b_psum), .out_down_psum_valid(b_pv));

  pe_ws_dbuf #(.DATA_W(DW), .PSUM_W(PW), .ACT_DELAY(ACT_DELAY), .MAC_LAT(MAC_LAT), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_swap(weight_swap),
    .in_up_weight(in_w), .out_down_weight(u_wout),
    .in_left_act(act), .in_left_valid(valid), .out_right_act(u_ract), .out_right_valid(u_rv),
    .in_up_psum(psum), .out_down_psum(u_psum), .out_down_psum_valid(u_pv));

  typedef struct {
    int            due;
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    logic          v;
  } psum_exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] a;
    logic          v;
  } act_exp_t;

  psum_exp_t     pq[$];
  act_exp_t      aq[$];
  logic [DW-1:0] m_sh[3];
  logic [DW-1:0] m_ac[3];
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic longint prod_of(input logic [DW-1:0] a, input logic [DW-1:0] w, input bit sgn);
    int ia;
    int iw;
    if (sgn) begin
      ia = int'($signed(a));
      iw = int'($signed(w));
    end else begin
      ia = {24'b0, a};
      iw = {24'b0, w};
    end
    return longint'(ia * iw);
  endfunction

  function automatic logic [PW-1:0] model_sum(input logic [PW-1:0] ps, input longint p, input bit sgn);
    longint s;
    if (sgn) s = longint'($signed(ps)) + p;
    else     s = longint'({32'b0, ps}) + p;
`ifdef PE_PSUM_SAT_EN
    if (sgn) begin
      if (s > 64'sd2147483647)       s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
    end else if (s > 64'sd4294967295) begin
      s = 64'sd4294967295;
    end
`endif
    return s[31:0];
  endfunction

  task automatic check_now();
    psum_exp_t e;
    act_exp_t  ae;
    chk("t_wout", {24'b0, t_wout}, {24'b0, m_sh[0]});
    chk("b_wout", {24'b0, b_wout}, {24'b0, m_sh[1]});
    chk("u_wout", {24'b0, u_wout}, {24'b0, m_sh[2]});
    while (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      chk("t_psum",  t_psum, e.p0);
      chk("t_pvld",  {31'b0, t_pv}, {31'b0, e.v});
      chk("b_psum",  b_psum, e.p1);
      chk("b_pvld",  {31'b0, b_pv}, {31'b0, e.v});
      chk("u_psum",  u_psum, e.p2);
      chk("u_pvld",  {31'b0, u_pv}, {31'b0, e.v});
    end
    while (aq.size() > 0 && aq[0].due == cyc) begin
      ae = aq.pop_front();
      chk("t_ract", {24'b0, t_ract}, {24'b0, ae.a});
      chk("t_rvld", {31'b0, t_rv}, {31'b0, ae.v});
      chk("u_ract", {24'b0, u_ract}, {24'b0, ae.a});
      chk("b_rvld", {31'b0, b_rv}, {31'b0, ae.v});
    end
  endtask

  // Called at a falling edge; drives one cycle of stimulus and checks after the rising edge.
  task automatic step(input logic ld, input logic sw, input logic [DW-1:0] w,
                      input logic [DW-1:0] a, input logic v, input logic [PW-1:0] ps);
    psum_exp_t     e;
    act_exp_t      ae;
    logic [DW-1:0] wuse[3];
    logic [DW-1:0] old_sh0;
    weight_load = ld;
    weight_swap = sw;
    in_w        = w;
    act         = a;
    valid       = v;
    psum        = ps;
    for (int i = 0; i < 3; i++) wuse[i] = sw ? m_sh[i] : m_ac[i];
    e.due = cyc + MAC_LAT;
    e.v   = v;
    e.p0  = model_sum(ps, v ? prod_of(a, wuse[0], 1'b1) : 64'sd0, 1'b1);
    e.p1  = model_sum(ps, v ? prod_of(a, wuse[1], 1'b1) : 64'sd0, 1'b1);
    e.p2  = model_sum(ps, v ? prod_of(a, wuse[2], 1'b0) : 64'sd0, 1'b0);
    pq.push_back(e);
    ae.due = cyc + ACT_DELAY;
    ae.a   = a;
    ae.v   = v;
    aq.push_back(ae);
    old_sh0 = m_sh[0];
    if (sw) for (int i = 0; i < 3; i++) m_ac[i] = m_sh[i];
    if (ld) begin
      m_sh[0] = w;
      m_sh[1] = old_sh0;
      m_sh[2] = w;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_now();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_t_psum"}, t_psum, 32'd0);
    chk({tag, "_t_pvld"}, {31'b0, t_pv}, 32'd0);
    chk({tag, "_t_ract"}, {24'b0, t_ract}, 32'd0);
    chk({tag, "_t_rvld"}, {31'b0, t_rv}, 32'd0);
    chk({tag, "_t_wout"}, {24'b0, t_wout}, 32'd0);
    chk({tag, "_b_psum"}, b_psum, 32'd0);
    chk({tag, "_b_pvld"}, {31'b0, b_pv}, 32'd0);
    chk({tag, "_b_wout"}, {24'b0, b_wout}, 32'd0);
    chk({tag, "_u_psum"}, u_psum, 32'd0);
    chk({tag, "_u_pvld"}, {31'b0, u_pv}, 32'd0);
    chk({tag, "_u_rvld"}, {31'b0, u_rv}, 32'd0);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Column fill: top ends with 5, bottom with 3.
    step(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 8'd5, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 32'd0);

    // 5 * -3 + 100 = 85
    step(1'b0, 1'b0, 8'd0, 8'hFD, 1'b1, 32'd100);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0);

    // Swap lands on the second of two back-to-back ops: 10 then 14.
    step(1'b1, 1'b0, 8'd7, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 32'd0);
    step(1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 32'd0);

    // Invalid act passes psum through untouched.
    step(1'b0, 1'b0, 8'd0, 8'd9, 1'b0, 32'd42);

    // Positive and negative overflow with weight 1.
    step(1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 32'h7FFF_FFFF);
    step(1'b0, 1'b0, 8'd0, 8'hFF, 1'b1, 32'h8000_0000);
    step(1'b0, 1'b0, 8'd0, 8'hFF, 1'b1, 32'hFFFF_FFFF);

    // 0xFF * 0xFF: 65025 unsigned, 1 signed.
    step(1'b1, 1'b0, 8'hFF, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'hFF, 1'b1, 32'd0);

    for (int k = 0; k < 40; k++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 8'($urandom),
           8'($urandom), 1'($urandom), $urandom);
    end

    // Reset mid-stream with valids high.
    step(1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 32'd7);
    step(1'b1, 1'b0, 8'd9, 8'd6, 1'b1, 32'd11);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    pq.delete();
    aq.delete();
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 32'd1);
    chk("rst_early_pvld", {31'b0, t_pv}, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0);

    repeat (3) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
